// File: rtl/result_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_monitor_pkg
// Description : Shared types and sizes for the result monitor and its
//               stability detector.
// Revision    : 1.0 - initial release
// ============================================================================
package result_monitor_pkg;

   localparam int NUM_WORDS = 7;
   localparam int WORD_W    = 32;
   localparam int IDX_W     = 3;

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_WAIT_STABLE = 2'd1,
      S_COMPARE     = 2'd2,
      S_DONE        = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/result_monitor_stability_detector.sv
`default_nettype none
// ============================================================================
// Module      : stability_detector
// Description : Snapshots the watched words every enabled cycle and counts
//               consecutive cycles with no change, saturating at
//               STABLE_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module stability_detector
   import result_monitor_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_en,
   input  logic              i_first,
   input  logic [WORD_W-1:0] i_mem  [NUM_WORDS],
   output logic              o_stable,
   output logic [WORD_W-1:0] o_snap [NUM_WORDS]
);

   localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;

   logic [WORD_W-1:0] r_snap [NUM_WORDS];
   logic [CNT_W-1:0]  r_cnt;
   logic              w_changed;

   // Any live word differing from its previous-cycle snapshot is a change.
   always_comb begin
      w_changed = 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (i_mem[i] != r_snap[i]) begin
            w_changed = 1'b1;
         end
      end
   end

   // Snapshot capture and saturating stable counter; the first enabled
   // cycle always counts as a change because the snapshot is stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_snap[i] <= '0;
         end
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_snap[i] <= i_mem[i];
         end
         if (i_first || w_changed) begin
            r_cnt <= '0;
         end else if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_stable = (r_cnt == CNT_W'(STABLE_CYCLES));
   assign o_snap   = r_snap;

endmodule
`default_nettype wire

// File: rtl/result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : result_monitor
// Description : Waits for seven observed memory words to settle, then
//               compares the frozen snapshot against expected values one word
//               per cycle and reports pass, timeout or first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module result_monitor
   import result_monitor_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 750
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] mem0, mem1, mem2, mem3, mem4, mem5, mem6,
   input  logic [WORD_W-1:0] exp0, exp1, exp2, exp3, exp4, exp5, exp6,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [WORD_W-1:0] fail_val
);

   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   state_t              r_state, w_next;
   logic [TCNT_W-1:0]   r_tcnt;
   logic [IDX_W-1:0]    r_idx;
   logic                r_pass, r_timeout;
   logic [IDX_W-1:0]    r_fail_idx;
   logic [WORD_W-1:0]   r_fail_val;

   logic [WORD_W-1:0]   w_mem  [NUM_WORDS];
   logic [WORD_W-1:0]   w_exp  [NUM_WORDS];
   logic [WORD_W-1:0]   w_snap [NUM_WORDS];
   logic                w_stable, w_start_acc, w_in_wait, w_first, w_mismatch;
   logic                w_last_idx, w_tmo_hit;

   assign w_mem = '{mem0, mem1, mem2, mem3, mem4, mem5, mem6};
   assign w_exp = '{exp0, exp1, exp2, exp3, exp4, exp5, exp6};

   assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_in_wait   = (r_state == S_WAIT_STABLE);
   assign w_first     = w_in_wait && (r_tcnt == '0);
   assign w_mismatch  = (w_snap[r_idx] != w_exp[r_idx]);
   assign w_last_idx  = (r_idx == IDX_W'(NUM_WORDS - 1));
   assign w_tmo_hit   = (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

   stability_detector #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_stab (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_start_acc),
      .i_en     (w_in_wait),
      .i_first  (w_first),
      .i_mem    (w_mem),
      .o_stable (w_stable),
      .o_snap   (w_snap)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; stability takes priority over an expiring timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) w_next = S_WAIT_STABLE;
         end
         S_WAIT_STABLE: begin
            if (w_stable)       w_next = S_COMPARE;
            else if (w_tmo_hit) w_next = S_DONE;
         end
         S_COMPARE: begin
            if (w_mismatch || w_last_idx) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Run counters and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt     <= '0;
         r_idx      <= '0;
         r_pass     <= 1'b0;
         r_timeout  <= 1'b0;
         r_fail_idx <= '0;
         r_fail_val <= '0;
      end else if (w_start_acc) begin
         r_tcnt     <= '0;
         r_idx      <= '0;
         r_pass     <= 1'b0;
         r_timeout  <= 1'b0;
         r_fail_idx <= '0;
         r_fail_val <= '0;
      end else if (w_in_wait) begin
         r_tcnt <= r_tcnt + 1'b1;
         r_idx  <= '0;
         if (!w_stable && w_tmo_hit) begin
            r_timeout <= 1'b1;
         end
      end else if (r_state == S_COMPARE) begin
         if (w_mismatch) begin
            r_fail_idx <= r_idx;
            r_fail_val <= w_snap[r_idx];
         end else if (w_last_idx) begin
            r_pass <= 1'b1;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign busy     = (r_state == S_WAIT_STABLE) || (r_state == S_COMPARE);
   assign done     = (r_state == S_DONE);
   assign pass     = r_pass;
   assign timeout  = r_timeout;
   assign fail_idx = r_fail_idx;
   assign fail_val = r_fail_val;

endmodule
`default_nettype wire

// File: tb/tb_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_monitor
// Description : Directed self-checking bench for result_monitor (default
//               parameters). Latencies are counted in rising edges after the
//               edge that accepts start: 1 snapshot-load edge + 16 stable
//               edges + 1 entry into COMPARE + (k+1) compare edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] mem  [7];
   logic [31:0] expv [7];
   logic        busy, done, pass, timeout;
   logic [2:0]  fail_idx;
   logic [31:0] fail_val;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   result_monitor dut (
      .clk(clk), .rst(rst), .start(start),
      .mem0(mem[0]), .mem1(mem[1]), .mem2(mem[2]), .mem3(mem[3]),
      .mem4(mem[4]), .mem5(mem[5]), .mem6(mem[6]),
      .exp0(expv[0]), .exp1(expv[1]), .exp2(expv[2]), .exp3(expv[3]),
      .exp4(expv[4]), .exp5(expv[5]), .exp6(expv[6]),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .fail_idx(fail_idx), .fail_val(fail_val)
   );

   task automatic set_default();
      for (int i = 0; i < 7; i++) begin
         mem[i]  = 32'(i + 1);
         expv[i] = 32'(i + 1);
      end
   endtask

   // Start goes high for one posedge (edge E0); returns at negedge after E0.
   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Counts edges after E0 until done; optional extra start pulse, mem0
   // toggling period and mem5 change point. n = -1 if the bound expires.
   task automatic wait_done(input int pulse_at, input int toggle_per,
                            input int chg_at, input logic [31:0] chg_val,
                            output int n);
      n = -1;
      for (int k = 1; k <= 1200; k++) begin
         @(negedge clk);
         start = (k == pulse_at);
         if (k == chg_at) mem[5] = chg_val;
         if (done) begin
            n = k;
            break;
         end
         if (toggle_per > 0 && (k % toggle_per) == 0) mem[0] = ~mem[0];
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (pass !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", pass, timeout); end
      checks++; if (fail_idx !== 3'd0 || fail_val !== 32'd0) begin failures++; $display("FAIL reset_fail got=%0d/%h want=0/0", fail_idx, fail_val); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_after_reset got=%b%b want=00", busy, done); end
   endtask

   task automatic test_all_match();
      int n;
      set_default();
      pulse_start();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL match_busy got=%b want=1", busy); end
      wait_done(0, 0, 0, 0, n);
      checks++; if (n !== 25) begin failures++; $display("FAIL match_latency got=%0d want=25", n); end
      checks++; if (pass !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL match_flags got=%b%b want=10", pass, timeout); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL match_busy_end got=%b want=0", busy); end
      checks++; if (fail_val !== 32'd0) begin failures++; $display("FAIL match_fail_val got=%h want=0", fail_val); end
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL match_done_held got=%b want=1", done); end
   endtask

   task automatic test_mismatch();
      int n;
      set_default();
      mem[3]  = 32'hDEADBEEF;
      expv[3] = 32'h4;
      pulse_start();
      wait_done(0, 0, 0, 0, n);
      checks++; if (n !== 22) begin failures++; $display("FAIL mis_latency got=%0d want=22", n); end
      checks++; if (pass !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL mis_flags got=%b%b want=00", pass, timeout); end
      checks++; if (fail_idx !== 3'd3) begin failures++; $display("FAIL mis_idx got=%0d want=3", fail_idx); end
      checks++; if (fail_val !== 32'hDEADBEEF) begin failures++; $display("FAIL mis_val got=%h want=deadbeef", fail_val); end
   endtask

   task automatic test_last_word_mismatch();
      int n;
      set_default();
      expv[6] = 32'h77;
      pulse_start();
      wait_done(0, 0, 0, 0, n);
      checks++; if (n !== 25) begin failures++; $display("FAIL mis6_latency got=%0d want=25", n); end
      checks++; if (pass !== 1'b0 || fail_idx !== 3'd6 || fail_val !== 32'h7) begin
         failures++; $display("FAIL mis6_result got=%b/%0d/%h want=0/6/7", pass, fail_idx, fail_val); end
   endtask

   task automatic test_timeout();
      int n;
      set_default();
      pulse_start();
      wait_done(0, 10, 0, 0, n);
      checks++; if (n !== 750) begin failures++; $display("FAIL tmo_latency got=%0d want=750", n); end
      checks++; if (timeout !== 1'b1 || pass !== 1'b0) begin failures++; $display("FAIL tmo_flags got=t%b p%b want=t1 p0", timeout, pass); end
      checks++; if (fail_val !== 32'd0) begin failures++; $display("FAIL tmo_fail_val got=%h want=0", fail_val); end
      set_default();
   endtask

   task automatic test_restart_count();
      int n;
      set_default();
      mem[5]  = 32'h55;
      expv[5] = 32'h6;
      pulse_start();
      // stable count is 15 after E16; changing mem5 then restarts it at E17
      wait_done(0, 0, 16, 32'h6, n);
      checks++; if (n !== 41) begin failures++; $display("FAIL restart_latency got=%0d want=41", n); end
      checks++; if (pass !== 1'b1) begin failures++; $display("FAIL restart_pass got=%b want=1", pass); end
   endtask

   task automatic test_reset_mid_compare();
      int n;
      int seen;
      set_default();
      pulse_start();
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b%b want=00", busy, done); end
      checks++; if (pass !== 1'b0 || timeout !== 1'b0 || fail_idx !== 3'd0 || fail_val !== 32'd0) begin
         failures++; $display("FAIL midrst_outputs got=%b%b/%0d/%h want=00/0/0", pass, timeout, fail_idx, fail_val); end
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_run got=%0d want=0", seen); end
      pulse_start();
      wait_done(0, 0, 0, 0, n);
      checks++; if (n !== 25 || pass !== 1'b1) begin failures++; $display("FAIL midrst_rerun got=%0d/%b want=25/1", n, pass); end
   endtask

   task automatic test_start_ignored();
      int n;
      set_default();
      pulse_start();
      wait_done(5, 0, 0, 0, n);
      checks++; if (n !== 25 || pass !== 1'b1) begin failures++; $display("FAIL ignore_start got=%0d/%b want=25/1", n, pass); end
   endtask

   task automatic test_back_to_back();
      int n;
      set_default();
      mem[1] = 32'h99;
      pulse_start();
      wait_done(0, 0, 0, 0, n);
      checks++; if (n !== 20 || fail_idx !== 3'd1) begin failures++; $display("FAIL b2b_first got=%0d/%0d want=20/1", n, fail_idx); end
      mem[1] = 32'h2;
      pulse_start();
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=d%b b%b want=d0 b1", done, busy); end
      checks++; if (fail_idx !== 3'd0 || fail_val !== 32'd0) begin failures++; $display("FAIL b2b_cleared got=%0d/%h want=0/0", fail_idx, fail_val); end
      wait_done(0, 0, 0, 0, n);
      checks++; if (n !== 25 || pass !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0d/%b want=25/1", n, pass); end
   endtask

   initial begin
      set_default();
      test_reset();
      test_all_match();
      test_mismatch();
      test_last_word_mismatch();
      test_timeout();
      test_restart_count();
      test_reset_mid_compare();
      test_start_ignored();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
